tg_debug_seq: RTL and testbench

Hardware sequencer that performs the supervisor's target-debug register access in RTL instead of in visor firmware. On a command from the visor it diverts the target code bus, forces an injected instruction through the target's EXR, captures the result from `tg_to_visor_reg`, restores the target's EXR from `exr_shadow`, and releases the target. It sits between the visor MCU's I/O registers and the target's debug port (`bus_ctrl` divert bit, `tg_force`, `tg_code_in`). It replaces the hand-timed firmware sequences and their fragile nop padding.

---
 rtl/tg_debug_pkg.sv | 61 ++++++
 rtl/tg_debug_seq.sv | 143 ++++++++++++++
 tb/tb_tg_debug_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tg_debug_pkg.sv
// Shared definitions for the target-debug sequencer.
//   - Bit positions inside tg_force and the bus_ctrl divert bit. The visor register map
//     uses the divert bit position too.
//   - Command op encodings and the sequencer state enum.
//   - The default base opcode of the "r15 = rN" observe instruction.
//   - Output decode helpers, so the per-state force/divert pattern lives in one place.
package tg_debug_pkg;

    localparam int unsigned FORCE_HOLD          = 0;
    localparam int unsigned FORCE_LOAD_EXR      = 1;
    localparam int unsigned FORCE_EXEC          = 2;
    localparam int unsigned BUS_CTRL_DIVERT_BIT = 2;

    localparam logic [15:0] OBSERVE_OPCODE = 16'h3C00;

    typedef enum logic [1:0] {
        OpObserve = 2'd0,
        OpExec    = 2'd1,
        OpRelease = 2'd2,
        OpRsvd    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        StIdle,
        StDivert,
        StLoad,
        StExec,
        StSettle,
        StCapture,
        StRestore,
        StUnhold,
        StRelease,
        StResp
    } state_e;

    // tg_force pattern presented while in state st
    function automatic logic [2:0] force_for(state_e st);
        logic [2:0] f;
        f = '0;
        unique case (st)
            StDivert, StSettle, StCapture: f[FORCE_HOLD] = 1'b1;
            StLoad, StRestore: begin
                f[FORCE_HOLD]     = 1'b1;
                f[FORCE_LOAD_EXR] = 1'b1;
            end
            StExec: begin
                f[FORCE_HOLD] = 1'b1;
                f[FORCE_EXEC] = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

    // Code bus stays diverted from DIVERT through UNHOLD inclusive
    function automatic logic divert_for(state_e st);
        return (st == StDivert) || (st == StLoad) || (st == StExec) || (st == StSettle) ||
               (st == StCapture) || (st == StRestore) || (st == StUnhold);
    endfunction

endpackage

// File: rtl/tg_debug_seq.sv
// Target-debug sequencer: on a visor command it diverts the target code bus, forces an
// injected instruction through the target EXR, captures tg_to_visor_reg, restores the EXR
// from the latched shadow and releases the target. All outputs are registered.
// Ports:
//   sysclk, sysreset        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_op, cmd_reg, cmd_instr command payload
//   rsp_valid/rsp_ready     response handshake; rsp_data, rsp_err response payload
//   bp_hit, exr_shadow      target halt status and EXR shadow
//   tg_to_visor_reg         target debug result register
//   divert_code_bus         bus_ctrl divert bit
//   tg_force, tg_code_in    target debug force controls and injected instruction
//   bp_rearm                one-cycle pulse that lets bp0 pass once
module tg_debug_seq #(
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter logic [15:0] OBSERVE_OPCODE = tg_debug_pkg::OBSERVE_OPCODE
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_reg,
    input  logic [15:0] cmd_instr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic        bp_hit,
    input  logic [15:0] exr_shadow,
    input  logic [15:0] tg_to_visor_reg,
    output logic        divert_code_bus,
    output logic [2:0]  tg_force,
    output logic [15:0] tg_code_in,
    output logic        bp_rearm
);
    import tg_debug_pkg::*;

    // Counter holds remaining SETTLE cycles minus one
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    op_e         w_op;
    logic        w_accept;
    logic        w_reject;
    logic [3:0]  r_settle_cnt;
    logic [15:0] r_instr;
    logic [15:0] r_shadow;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_divert;
    logic [2:0]  r_force;
    logic [15:0] r_code_in;
    logic        r_bp_rearm;

    assign w_op     = op_e'(cmd_op);
    assign w_accept = cmd_valid & r_cmd_ready;
    assign w_reject = (w_op == OpRsvd) || ((w_op != OpRelease) && !bp_hit);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    // Release and rejected commands take one idle hop through RELEASE so
                    // the response appears one cycle after the bp_rearm pulse.
                    if (w_reject || (w_op == OpRelease)) begin
                        w_state_next = StRelease;
                    end else begin
                        w_state_next = StDivert;
                    end
                end
            end
            StDivert:  w_state_next = StLoad;
            StLoad:    w_state_next = StExec;
            StExec:    w_state_next = StSettle;
            StSettle:  if (r_settle_cnt == 4'd0) w_state_next = StCapture;
            StCapture: w_state_next = StRestore;
            StRestore: w_state_next = StUnhold;
            StUnhold:  w_state_next = StRelease;
            StRelease: w_state_next = StResp;
            StResp:    if (rsp_ready) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet match the state
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_state      <= StIdle;
            r_settle_cnt <= '0;
            r_instr      <= '0;
            r_shadow     <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_divert     <= 1'b0;
            r_force      <= '0;
            r_code_in    <= '0;
            r_bp_rearm   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == StIdle);
            r_rsp_valid <= (w_state_next == StResp);
            r_divert    <= divert_for(w_state_next);
            r_force     <= force_for(w_state_next);
            r_code_in   <= (w_state_next == StLoad)    ? r_instr  :
                           (w_state_next == StRestore) ? r_shadow : '0;
            r_bp_rearm  <= w_accept && (w_op == OpRelease);

            if (r_state == StExec) begin
                r_settle_cnt <= SETTLE_LOAD;
            end else if ((r_state == StSettle) && (r_settle_cnt != 4'd0)) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end

            if (w_accept) begin
                r_instr    <= (w_op == OpObserve) ? (OBSERVE_OPCODE | {12'd0, cmd_reg})
                                                  : cmd_instr;
                r_shadow   <= exr_shadow;
                r_rsp_data <= '0;
                r_rsp_err  <= w_reject;
            end else if (r_state == StCapture) begin
                r_rsp_data <= tg_to_visor_reg;
            end else if ((r_state == StResp) && rsp_ready) begin
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_data        = r_rsp_data;
    assign rsp_err         = r_rsp_err;
    assign divert_code_bus = r_divert;
    assign tg_force        = r_force;
    assign tg_code_in      = r_code_in;
    assign bp_rearm        = r_bp_rearm;

endmodule

// File: tb/tb_tg_debug_seq.sv
// Directed bench for tg_debug_seq: one instance with default settle, one with settle = 3.
module tb_tg_debug_seq;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic        cmd_valid, cmd_valid3;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_instr;
    logic        rsp_ready, rsp_ready3;
    logic        bp_hit;
    logic [15:0] exr_shadow;
    logic [15:0] tg_to_visor_reg = 16'h0000;
    logic [15:0] model_val;

    logic        cmd_ready, rsp_valid, rsp_err, divert_code_bus, bp_rearm;
    logic [15:0] rsp_data, tg_code_in;
    logic [2:0]  tg_force;
    logic        cmd_ready3, rsp_valid3, rsp_err3, divert3, bp_rearm3;
    logic [15:0] rsp_data3, tg_code_in3;
    logic [2:0]  tg_force3;

    int n_checks = 0;
    int n_errors = 0;
    int rearm_cnt = 0;
    int base;

    tg_debug_seq dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
        .cmd_instr(cmd_instr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .bp_hit(bp_hit), .exr_shadow(exr_shadow),
        .tg_to_visor_reg(tg_to_visor_reg), .divert_code_bus(divert_code_bus),
        .tg_force(tg_force), .tg_code_in(tg_code_in), .bp_rearm(bp_rearm)
    );

    tg_debug_seq #(.SETTLE_CYCLES(3)) dut3 (
        .sysclk(sysclk), .sysreset(sysreset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
        .cmd_instr(cmd_instr), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3), .bp_hit(bp_hit), .exr_shadow(exr_shadow),
        .tg_to_visor_reg(tg_to_visor_reg), .divert_code_bus(divert3),
        .tg_force(tg_force3), .tg_code_in(tg_code_in3), .bp_rearm(bp_rearm3)
    );

    always #5 sysclk = ~sysclk;

    // Target model: an exec strobe makes the result register take the prepared value
    always @(posedge sysclk) begin
        if (tg_force == 3'b101) tg_to_visor_reg <= model_val;
    end

    always @(negedge sysclk) begin
        if (bp_rearm) rearm_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    logic [2:0]  exp_force [8];
    logic        exp_div   [8];
    logic [15:0] exp_code  [8];

    initial begin
        exp_force = '{3'b011, 3'b101, 3'b001, 3'b001, 3'b011, 3'b000, 3'b000, 3'b000};
        exp_div   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_code  = '{16'h3C07, 16'h0, 16'h0, 16'h0, 16'hA5A5, 16'h0, 16'h0, 16'h0};

        sysreset = 1'b1;
        cmd_valid = 0; cmd_valid3 = 0; cmd_op = 0; cmd_reg = 0; cmd_instr = 0;
        rsp_ready = 0; rsp_ready3 = 0; bp_hit = 0; exr_shadow = 0; model_val = 0;
        repeat (2) @(posedge sysclk);
        #1 sysreset = 1'b0;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_divert", 32'(divert_code_bus), 32'd0);
        check_eq("rst_force", 32'(tg_force), 32'd0);

        // Observe r7 while halted; inputs changed after acceptance must be ignored
        bp_hit = 1; cmd_op = 2'd0; cmd_reg = 4'd7; exr_shadow = 16'hA5A5;
        model_val = 16'h1234; cmd_valid = 1;
        tick();
        cmd_valid = 0; exr_shadow = 16'hFFFF; bp_hit = 0; cmd_reg = 4'd0;
        check_eq("obs_divert_0", 32'(divert_code_bus), 32'd1);
        check_eq("obs_force_0", 32'(tg_force), 32'd1);
        check_eq("obs_cmd_ready_0", 32'(cmd_ready), 32'd0);
        for (int n = 1; n <= 8; n++) begin
            tick();
            check_eq($sformatf("obs_force_%0d", n), 32'(tg_force), 32'(exp_force[n-1]));
            check_eq($sformatf("obs_div_%0d", n), 32'(divert_code_bus), 32'(exp_div[n-1]));
            check_eq($sformatf("obs_code_%0d", n), 32'(tg_code_in), 32'(exp_code[n-1]));
            check_eq($sformatf("obs_rspv_%0d", n), 32'(rsp_valid), 32'(n == 8));
        end
        check_eq("obs_data", 32'(rsp_data), 32'h1234);
        check_eq("obs_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check_eq("obs_rspv_done", 32'(rsp_valid), 32'd0);
        check_eq("obs_cmd_ready_done", 32'(cmd_ready), 32'd1);

        // Release with rsp_ready tied high
        base = rearm_cnt;
        cmd_op = 2'd2; bp_hit = 1; cmd_valid = 1; rsp_ready = 1;
        tick();
        cmd_valid = 0;
        check_eq("rel_rearm_0", 32'(bp_rearm), 32'd1);
        check_eq("rel_cmd_ready_0", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("rel_rearm_1", 32'(bp_rearm), 32'd0);
        check_eq("rel_rspv_1", 32'(rsp_valid), 32'd1);
        check_eq("rel_data", 32'(rsp_data), 32'd0);
        check_eq("rel_err", 32'(rsp_err), 32'd0);
        tick();
        rsp_ready = 0;
        check_eq("rel_cmd_ready_2", 32'(cmd_ready), 32'd1);
        check_eq("rel_rspv_2", 32'(rsp_valid), 32'd0);
        check_eq("rel_pulses", 32'(rearm_cnt - base), 32'd1);

        // Not halted: rejected without touching the target
        bp_hit = 0; cmd_op = 2'd0; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        check_eq("nh_rspv_0", 32'(rsp_valid), 32'd0);
        check_eq("nh_div_0", 32'(divert_code_bus), 32'd0);
        check_eq("nh_force_0", 32'(tg_force), 32'd0);
        tick();
        check_eq("nh_rspv_1", 32'(rsp_valid), 32'd1);
        check_eq("nh_err_1", 32'(rsp_err), 32'd1);
        check_eq("nh_data_1", 32'(rsp_data), 32'd0);
        check_eq("nh_div_1", 32'(divert_code_bus), 32'd0);
        check_eq("nh_force_1", 32'(tg_force), 32'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check_eq("nh_cmd_ready", 32'(cmd_ready), 32'd1);

        // Exec with response backpressure; a pending release must not be accepted
        bp_hit = 1; cmd_op = 2'd1; cmd_instr = 16'h5A5A; model_val = 16'hBEEF; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        tick();
        check_eq("bp_code_load", 32'(tg_code_in), 32'h5A5A);
        for (int n = 0; n < 20 && !rsp_valid; n++) tick();
        check_eq("bp_wait", 32'(rsp_valid), 32'd1);
        check_eq("bp_data", 32'(rsp_data), 32'hBEEF);
        base = rearm_cnt;
        cmd_op = 2'd2; cmd_valid = 1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check_eq($sformatf("bp_rspv_%0d", n), 32'(rsp_valid), 32'd1);
            check_eq($sformatf("bp_data_%0d", n), 32'(rsp_data), 32'hBEEF);
            check_eq($sformatf("bp_cmd_ready_%0d", n), 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 0;
        check_eq("bp_no_accept", 32'(rearm_cnt - base), 32'd0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check_eq("bp_cmd_ready_done", 32'(cmd_ready), 32'd1);

        // Settle of 3 cycles on the second instance
        cmd_op = 2'd0; cmd_reg = 4'd2; bp_hit = 1; cmd_valid3 = 1;
        tick();
        cmd_valid3 = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            check_eq($sformatf("s3_rspv_%0d", n), 32'(rsp_valid3), 32'(n == 10));
        end
        rsp_ready3 = 1;
        tick();
        rsp_ready3 = 0;
        check_eq("s3_cmd_ready", 32'(cmd_ready3), 32'd1);

        // Reset asserted while in EXEC
        cmd_valid3 = 1;
        tick();
        cmd_valid3 = 0;
        tick();
        tick();
        check_eq("rst_exec_force", 32'(tg_force3), 32'b101);
        check_eq("rst_exec_div", 32'(divert3), 32'd1);
        #2 sysreset = 1'b1;
        #1;
        check_eq("rst_async_force", 32'(tg_force3), 32'd0);
        check_eq("rst_async_div", 32'(divert3), 32'd0);
        check_eq("rst_async_cmd_ready", 32'(cmd_ready3), 32'd1);
        @(posedge sysclk);
        #1 sysreset = 1'b0;
        tick();
        check_eq("rst_after_cmd_ready", 32'(cmd_ready3), 32'd1);
        check_eq("rst_after_rspv", 32'(rsp_valid3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
